// File: rtl/robot_pkg.sv
// Shared definitions for the robot mission sequencer: direction codes, map
// bounds, FSM states, error codes and the step timeout.
package robot_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'b00,
    DIR_S = 2'b01,
    DIR_E = 2'b10,
    DIR_W = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_UPDATE,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MAP      = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_CONFLICT = 2'b11
  } err_e;

  localparam logic [3:0] MAP_ROWS       = 4'd10;
  localparam logic [4:0] MAP_COLS       = 5'd20;
  localparam logic [4:0] TIMEOUT_CYCLES = 5'd16;

  function automatic logic in_map(logic [3:0] r, logic [4:0] c);
    return (r >= 4'd1) && (r <= MAP_ROWS) && (c >= 5'd1) && (c <= MAP_COLS);
  endfunction

endpackage

// File: rtl/robot_pose_tracker.sv
// Next-pose computation for one robot action plus map bounds check.
// Front has priority over turn; the caller rejects conflicting actions.
module robot_pose_tracker
  import robot_pkg::*;
(
  input  logic [3:0] row,
  input  logic [4:0] col,
  input  logic [1:0] dir,
  input  logic       front,
  input  logic       turn,
  output logic [3:0] next_row,
  output logic [4:0] next_col,
  output logic [1:0] next_dir,
  output logic       out_of_map
);

  always_comb begin
    next_row   = row;
    next_col   = col;
    next_dir   = dir;
    out_of_map = 1'b0;
    if (front) begin
      case (dir)
        DIR_N:   next_row = row - 4'd1;
        DIR_S:   next_row = row + 4'd1;
        DIR_E:   next_col = col + 5'd1;
        default: next_col = col - 5'd1;
      endcase
      out_of_map = !in_map(next_row, next_col);
    end else if (turn) begin
      // Left rotation: N->W->S->E->N
      case (dir)
        DIR_N:   next_dir = DIR_W;
        DIR_W:   next_dir = DIR_S;
        DIR_S:   next_dir = DIR_E;
        default: next_dir = DIR_N;
      endcase
    end
  end

endmodule

// File: rtl/robot_mission_sequencer.sv
// Mission sequencer: launches a robot mission, requests one step at a time,
// tracks pose, step and trash counters, and flags map/timeout/conflict errors.
module robot_mission_sequencer
  import robot_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] init_row,
  input  logic [4:0] init_col,
  input  logic [1:0] init_dir,
  input  logic [8:0] n_moves,
  output logic       step_req,
  input  logic       act_valid,
  input  logic       front,
  input  logic       turn,
  input  logic       remove,
  output logic [3:0] row,
  output logic [4:0] col,
  output logic [1:0] dir,
  output logic [8:0] moves_done,
  output logic [7:0] trash_count,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  state_e     state, state_next;
  logic [8:0] n_moves_q;
  logic       act_front, act_turn, act_remove;
  logic [4:0] tmo_cnt;
  logic [1:0] phase;

  logic [3:0] next_row;
  logic [4:0] next_col;
  logic [1:0] next_dir;
  logic       out_of_map;

  logic can_start, init_ok, conflict, tmo_hit, last_move;
  logic step_req_d, busy_d, done_d, error_d;

  assign can_start = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign init_ok   = in_map(init_row, init_col);
  assign conflict  = (act_front & act_turn) | (act_front & act_remove) | (act_turn & act_remove);
  assign tmo_hit   = (tmo_cnt == TIMEOUT_CYCLES - 5'd1);
  assign last_move = ((moves_done + 9'd1) == n_moves_q);

  robot_pose_tracker u_pose (
    .row        (row),
    .col        (col),
    .dir        (dir),
    .front      (act_front),
    .turn       (act_turn),
    .next_row   (next_row),
    .next_col   (next_col),
    .next_dir   (next_dir),
    .out_of_map (out_of_map)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (can_start) begin
          if (!init_ok)              state_next = ST_ERROR;
          else if (n_moves == 9'd0)  state_next = ST_DONE;
          else                       state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (act_valid)    state_next = ST_UPDATE;
        else if (tmo_hit) state_next = ST_ERROR;
      end
      ST_UPDATE: begin
        if (conflict || out_of_map) state_next = ST_ERROR;
        else if (last_move)         state_next = ST_DONE;
        else                        state_next = ST_ISSUE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status flags are decoded from the next state and registered so they
  // line up with the state register.
  always_comb begin
    step_req_d = (state_next == ST_ISSUE);
    busy_d     = (state_next == ST_ISSUE) || (state_next == ST_UPDATE);
    done_d     = (state_next == ST_DONE);
    error_d    = (state_next == ST_ERROR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_req <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      step_req <= step_req_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row         <= 4'd1;
      col         <= 5'd1;
      dir         <= DIR_N;
      n_moves_q   <= '0;
      moves_done  <= '0;
      trash_count <= '0;
      phase       <= '0;
      err_code    <= ERR_NONE;
      tmo_cnt     <= '0;
      act_front   <= 1'b0;
      act_turn    <= 1'b0;
      act_remove  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (can_start) begin
            row         <= init_row;
            col         <= init_col;
            dir         <= init_dir;
            n_moves_q   <= n_moves;
            moves_done  <= '0;
            trash_count <= '0;
            phase       <= '0;
            tmo_cnt     <= '0;
            err_code    <= init_ok ? ERR_NONE : ERR_MAP;
          end
        end
        ST_ISSUE: begin
          if (act_valid) begin
            act_front  <= front;
            act_turn   <= turn;
            act_remove <= remove;
          end else if (tmo_hit) begin
            err_code <= ERR_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 5'd1;
          end
        end
        ST_UPDATE: begin
          tmo_cnt <= '0;
          if (conflict) begin
            err_code <= ERR_CONFLICT;
          end else if (out_of_map) begin
            err_code <= ERR_MAP;
          end else begin
            row        <= next_row;
            col        <= next_col;
            dir        <= next_dir;
            moves_done <= moves_done + 9'd1;
            if (act_remove) begin
              // Every third removal completes one piece of trash
              if (phase == 2'd2) begin
                phase <= '0;
                if (trash_count != '1) trash_count <= trash_count + 8'd1;
              end else begin
                phase <= phase + 2'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
